bit_serializer: RTL

BIT_SERIALIZER -- requirements
Module: bit_serializer

---
 rtl/bit_serializer_pkg.sv | 18 +
 rtl/piso_shift_reg.sv | 30 +++
 rtl/bit_serializer.sv | 102 ++++++++++
 3 files changed

// File: rtl/bit_serializer_pkg.sv
// Shared types and sizing helpers for the bit serializer.
package bit_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Gap counter covers GAP_CYCLES up to 15.
  localparam int GAP_W = 4;

  // Bit-counter width: ceil(log2(w)), never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register; the presented bit is always the
// head of the register, and shifting fills the vacated end with zeros.
module piso_shift_reg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] data,
  output logic             serial_bit
);

  logic [WIDTH-1:0] q;

  always_ff @(posedge clock) begin
    if (clear) begin
      q <= '0;
    end else if (load) begin
      q <= data;
    end else if (shift) begin
      if (MSB_FIRST) q <= {q[WIDTH-2:0], 1'b0};
      else           q <= {1'b0, q[WIDTH-1:1]};
    end
  end

  assign serial_bit = MSB_FIRST ? q[WIDTH-1] : q[0];

endmodule

// File: rtl/bit_serializer.sv
// Frame serializer: accepts a parallel word over a valid/ready handshake and
// streams it one bit per cycle, with optional idle gap between frames.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             frame_done,
  output state_t           fsm_state
);

  // Handshake: a frame transfers on the rising edge where load_valid and
  // load_ready are both high; load_ready never depends on load_valid.

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0]    BIT_LAST = CW'(WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  state_t             state;
  state_t             state_next;
  logic [CW-1:0]      bit_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic               last_bit;
  logic               accept;
  logic               shift_en;
  logic               sr_bit;

  assign last_bit  = (state == SHIFT) && (bit_cnt == BIT_LAST);
  assign fsm_state = state;

  always_comb begin
    state_next   = state;
    load_ready   = 1'b0;
    accept       = 1'b0;
    shift_en     = 1'b0;
    serial_valid = 1'b0;
    frame_done   = 1'b0;
    serial_out   = IDLE_LEVEL;

    // Reset masks every output so nothing of an aborted frame leaks out.
    load_ready   = !reset && ((state == IDLE) || (last_bit && (GAP_CYCLES == 0)));
    accept       = load_valid && load_ready;
    shift_en     = (state == SHIFT) && !accept;
    serial_valid = !reset && (state == SHIFT);
    frame_done   = !reset && last_bit;
    serial_out   = serial_valid ? sr_bit : IDLE_LEVEL;

    case (state)
      IDLE: begin
        if (accept) state_next = SHIFT;
      end
      SHIFT: begin
        if (last_bit) begin
          if (accept)              state_next = SHIFT;
          else if (GAP_CYCLES > 0) state_next = GAP;
          else                     state_next = IDLE;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      state <= state_next;
      if (accept)              bit_cnt <= '0;
      else if (state == SHIFT) bit_cnt <= last_bit ? '0 : bit_cnt + CW'(1);
      if (state == GAP) gap_cnt <= gap_cnt + GAP_W'(1);
      else              gap_cnt <= '0;
    end
  end

  piso_shift_reg #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_sr (
    .clock     (clock),
    .clear     (reset),
    .load      (accept),
    .shift     (shift_en),
    .data      (load_data),
    .serial_bit(sr_bit)
  );

endmodule
